// File: rtl/move_log_pkg.sv
// rtl/move_log_pkg.sv - shared move-log constants and move codes
package move_log_pkg;

    localparam int MAX_MOVES = 17;
    localparam int MW        = 2;
    localparam int ORD_W     = MAX_MOVES * MW;
    localparam int DW        = 5;

    typedef enum logic [MW-1:0] {
        MV_UP    = 2'd0,
        MV_DOWN  = 2'd1,
        MV_RIGHT = 2'd2,
        MV_LEFT  = 2'd3
    } move_t;

endpackage

// File: rtl/move_log_if.sv
// rtl/move_log_if.sv - solver-to-move-log control and status bundle
interface move_log_if;
    import move_log_pkg::*;

    logic             clr;
    logic             push;
    logic [MW-1:0]    push_move;
    logic             pop;
    logic             goal;
    logic [ORD_W-1:0] ord;
    logic             comp;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic [MW-1:0]    last_move;
    logic             overflow;

    modport master (
        output clr, push, push_move, pop, goal,
        input  ord, comp, depth, empty, full, last_move, overflow
    );

    modport slave (
        input  clr, push, push_move, pop, goal,
        output ord, comp, depth, empty, full, last_move, overflow
    );

endinterface

// File: rtl/move_log.sv
// rtl/move_log.sv - bounded LIFO of solver moves packed for the display stage
module move_log
    import move_log_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    move_log_if.slave  bus
);

    logic [ORD_W-1:0]     ord_q;
    logic [DW-1:0]        depth_q;
    logic                 comp_q;
    logic                 ovf_q;

    logic [DW-1:0]        depth_d;
    logic                 comp_d;
    logic                 ovf_d;
    logic                 wr_en;
    logic [DW-1:0]        wr_idx;
    logic [MW-1:0]        wr_val;
    logic [MAX_MOVES-1:0] slot_we;
    logic                 is_empty;
    logic                 is_full;

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DW'(MAX_MOVES));

    // Decide the single slot write (if any) and the next depth/flags; frozen log ignores solver inputs.
    always_comb begin
        depth_d = depth_q;
        comp_d  = comp_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_val  = '0;
        if (!comp_q) begin
            if (bus.push && bus.pop && !is_empty) begin
                // Replace the top move in place; legal even when full.
                wr_en  = 1'b1;
                wr_idx = depth_q - 1'b1;
                wr_val = bus.push_move;
            end else if (bus.push) begin
                if (!is_full) begin
                    wr_en   = 1'b1;
                    wr_idx  = depth_q;
                    wr_val  = bus.push_move;
                    depth_d = depth_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (bus.pop && !is_empty) begin
                // Zero the vacated slot so everything above depth reads 0.
                wr_en   = 1'b1;
                wr_idx  = depth_q - 1'b1;
                depth_d = depth_q - 1'b1;
            end
            if (bus.goal) begin
                comp_d = 1'b1;
            end
        end
    end

    // One-hot slot write enables; wr_idx never reaches MAX_MOVES when wr_en is set.
    for (genvar k = 0; k < MAX_MOVES; k++) begin : g_slot_we
        assign slot_we[k] = wr_en && (wr_idx == DW'(k));
    end

    // Log registers: async reset, clr wins over every other input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ord_q   <= '0;
            depth_q <= '0;
            comp_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.clr) begin
            ord_q   <= '0;
            depth_q <= '0;
            comp_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            comp_q  <= comp_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < MAX_MOVES; k++) begin
                if (slot_we[k]) begin
                    ord_q[k*MW +: MW] <= wr_val;
                end
            end
        end
    end

    // Top-of-log decode from registered state only; reads 0 when empty.
    always_comb begin
        bus.last_move = '0;
        for (int k = 0; k < MAX_MOVES; k++) begin
            if (depth_q == DW'(k + 1)) begin
                bus.last_move = ord_q[k*MW +: MW];
            end
        end
    end

    assign bus.ord      = ord_q;
    assign bus.depth    = depth_q;
    assign bus.comp     = comp_q;
    assign bus.overflow = ovf_q;
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;

endmodule

// File: tb/tb_move_log.sv
// tb/tb_move_log.sv - randomized and directed bench for move_log against a queue model
module tb_move_log;
    import move_log_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    move_log_if bus();

    move_log dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [MW-1:0] mq[$];
    bit            m_comp;
    bit            m_ovf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_ord();
        logic [63:0] r = '0;
        foreach (mq[k]) r = r | (64'(mq[k]) << (MW * k));
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_comp = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ord"},   64'(bus.ord),       m_ord());
        chk({tag, "_depth"}, 64'(bus.depth),     64'(mq.size()));
        chk({tag, "_comp"},  64'(bus.comp),      64'(m_comp));
        chk({tag, "_ovf"},   64'(bus.overflow),  64'(m_ovf));
        chk({tag, "_empty"}, 64'(bus.empty),     64'(mq.size() == 0));
        chk({tag, "_full"},  64'(bus.full),      64'(mq.size() == MAX_MOVES));
        chk({tag, "_last"},  64'(bus.last_move), (mq.size() == 0) ? 64'd0 : 64'(mq[mq.size()-1]));
    endtask

    task automatic step(input string tag, input bit c, input bit p, input logic [MW-1:0] mv,
                        input bit po, input bit g);
        @(negedge clk);
        bus.clr = c; bus.push = p; bus.push_move = mv; bus.pop = po; bus.goal = g;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else if (!m_comp) begin
            if (p && po && mq.size() > 0) mq[mq.size()-1] = mv;
            else if (p) begin
                if (mq.size() < MAX_MOVES) mq.push_back(mv);
                else m_ovf = 1'b1;
            end else if (po && mq.size() > 0) void'(mq.pop_back());
            if (g) m_comp = 1'b1;
        end
        #1;
        bus.clr = 0; bus.push = 0; bus.push_move = 0; bus.pop = 0; bus.goal = 0;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.clr = 0; bus.push = 0; bus.push_move = 0; bus.pop = 0; bus.goal = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("rst");
        rst_n = 1'b1;

        // Activity then mid-cycle reset
        for (int i = 0; i < 4; i++) step("pre", 0, 1, MW'($urandom), 0, 0);
        async_reset("t1");

        // Three pushes
        step("t2a", 0, 1, 2'b01, 0, 0);
        step("t2b", 0, 1, 2'b10, 0, 0);
        step("t2c", 0, 1, 2'b11, 0, 0);
        chk("t2_ord", 64'(bus.ord), 64'h39);
        chk("t2_depth", 64'(bus.depth), 64'd3);
        chk("t2_last", 64'(bus.last_move), 64'd3);

        // Pop, replace, pop to empty and beyond
        step("t3a", 0, 0, 2'b00, 1, 0);
        chk("t3_ord_pop", 64'(bus.ord), 64'h09);
        step("t3b", 0, 1, 2'b00, 1, 0);
        chk("t3_ord_rep", 64'(bus.ord), 64'h01);
        chk("t3_last_rep", 64'(bus.last_move), 64'd0);
        chk("t3_depth_rep", 64'(bus.depth), 64'd2);
        step("t3c", 0, 0, 2'b00, 1, 0);
        step("t3d", 0, 0, 2'b00, 1, 0);
        step("t3e", 0, 0, 2'b00, 1, 0);
        chk("t3_empty", 64'(bus.empty), 64'd1);

        // Fill, overflow, replace top while full
        for (int i = 0; i < MAX_MOVES; i++) step("t4f", 0, 1, 2'b11, 0, 0);
        chk("t4_ord_full", 64'(bus.ord), 64'h3_FFFF_FFFF);
        chk("t4_full", 64'(bus.full), 64'd1);
        step("t4o", 0, 1, 2'b01, 0, 0);
        chk("t4_ovf", 64'(bus.overflow), 64'd1);
        chk("t4_ord_ovf", 64'(bus.ord), 64'h3_FFFF_FFFF);
        step("t4r", 0, 1, 2'b00, 1, 0);
        chk("t4_ord_rep", 64'(bus.ord), 64'h0_FFFF_FFFF);
        chk("t4_depth_rep", 64'(bus.depth), 64'd17);

        // Goal with final push, then frozen
        step("t5c", 1, 0, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++) step("t5p", 0, 1, MW'($urandom), 0, 0);
        step("t5g", 0, 1, 2'b10, 0, 1);
        chk("t5_depth", 64'(bus.depth), 64'd4);
        chk("t5_slot3", 64'(bus.ord[7:6]), 64'd2);
        chk("t5_comp", 64'(bus.comp), 64'd1);
        step("t5x", 0, 1, 2'b01, 0, 0);
        step("t5y", 0, 0, 2'b00, 1, 0);
        step("t5z", 0, 1, 2'b11, 1, 1);
        step("t5clr", 1, 0, 2'b00, 0, 0);
        chk("t5_clr_ord", 64'(bus.ord), 64'd0);
        chk("t5_clr_comp", 64'(bus.comp), 64'd0);

        // clr beats push; goal on empty log
        for (int i = 0; i < 5; i++) step("t6p", 0, 1, MW'($urandom), 0, 0);
        step("t6c", 1, 1, 2'b11, 0, 0);
        chk("t6_depth", 64'(bus.depth), 64'd0);
        step("t6g", 0, 0, 2'b00, 0, 1);
        chk("t6_comp", 64'(bus.comp), 64'd1);
        chk("t6_ord", 64'(bus.ord), 64'd0);
        step("t6clr", 1, 0, 2'b00, 0, 0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if (i % 200 == 199) async_reset("rnd_rst");
            step("rnd",
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 6,
                 MW'($urandom),
                 $urandom_range(0, 9) < 4,
                 $urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
